// File: rtl/omem_psum_buffer_if.sv
// Bundle of PE write, accumulator read, drain control and writeback signals for omem_psum_buffer.
// The buffer uses the slave modport and its driver uses the master modport.
interface omem_psum_buffer_if #(
  parameter int PSUM_DW = 24,
  parameter int OUT_CH  = 16,
  parameter int CH_W    = $clog2(OUT_CH)
) ();

  logic               pe_out_valid;
  logic [CH_W-1:0]    pe_out_ch;
  logic [PSUM_DW-1:0] pe_ofmap;
  logic               rd_req;
  logic [CH_W-1:0]    rd_ch;
  logic [PSUM_DW-1:0] psum;
  logic               acc_valid;
  logic               drain_start;
  logic               drain_busy;
  logic               drain_done;
  logic               wb_valid;
  logic               wb_ready;
  logic [CH_W-1:0]    wb_ch;
  logic [PSUM_DW-1:0] wb_data;
  logic               err;

  modport master (
    output pe_out_valid, pe_out_ch, pe_ofmap, rd_req, rd_ch, drain_start, wb_ready,
    input  psum, acc_valid, drain_busy, drain_done, wb_valid, wb_ch, wb_data, err
  );

  modport slave (
    input  pe_out_valid, pe_out_ch, pe_ofmap, rd_req, rd_ch, drain_start, wb_ready,
    output psum, acc_valid, drain_busy, drain_done, wb_valid, wb_ch, wb_data, err
  );

endinterface

// File: rtl/omem_psum_buffer.sv
// Channel-indexed partial-sum buffer with a write-first read port and a valid/ready drain FSM.
// Optional macro OMEM_RELU_EN clamps negative drained values to zero on the writeback path only.
module omem_psum_buffer #(
  parameter int PSUM_DW = 24,
  parameter int OUT_CH  = 16,
  parameter int CH_W    = $clog2(OUT_CH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  omem_psum_buffer_if.slave psum_bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [CH_W-1:0] LAST_IDX = CH_W'(OUT_CH - 1);

  logic [PSUM_DW-1:0] entryData_q [OUT_CH];
  logic [OUT_CH-1:0]  entryVld_q, entryVld_d;
  state_e             state_q, state_d;
  logic [CH_W-1:0]    drainIdx_q, drainIdx_d;
  logic [PSUM_DW-1:0] psum_q, psum_d;
  logic               accValid_q, accValid_d;
  logic               err_q, err_d;

  logic               wrEn;
  logic               rdEn;
  logic               wbFire;
  logic               inDrain;
  logic [PSUM_DW-1:0] drainRaw;
  logic [PSUM_DW-1:0] drainData;

  // PE traffic is only honoured in IDLE; anything else is a protocol error.
  assign wrEn    = psum_bus.pe_out_valid && (state_q == IDLE);
  assign rdEn    = psum_bus.rd_req && (state_q == IDLE);
  assign inDrain = (state_q == DRAIN);
  assign wbFire  = inDrain && psum_bus.wb_ready;
  assign err_d   = err_q | ((psum_bus.pe_out_valid | psum_bus.rd_req) & (state_q != IDLE));

  assign drainRaw = entryVld_q[drainIdx_q] ? entryData_q[drainIdx_q] : '0;

`ifdef OMEM_RELU_EN
  assign drainData = drainRaw[PSUM_DW-1] ? '0 : drainRaw;
`else
  assign drainData = drainRaw;
`endif

  // Read port with write-first bypass for a same-channel write in the same cycle.
  always_comb begin
    psum_d     = '0;
    accValid_d = 1'b0;
    if (rdEn) begin
      if (wrEn && (psum_bus.pe_out_ch == psum_bus.rd_ch)) begin
        psum_d     = psum_bus.pe_ofmap;
        accValid_d = 1'b1;
      end else if (entryVld_q[psum_bus.rd_ch]) begin
        psum_d     = entryData_q[psum_bus.rd_ch];
        accValid_d = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    drainIdx_d = drainIdx_q;
    entryVld_d = entryVld_q;
    if (wrEn) begin
      entryVld_d[psum_bus.pe_out_ch] = 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (psum_bus.drain_start) begin
          state_d    = DRAIN;
          drainIdx_d = '0;
        end
      end
      DRAIN: begin
        // The index wraps to zero on the final beat, leaving it ready for the next drain.
        if (wbFire) begin
          entryVld_d[drainIdx_q] = 1'b0;
          drainIdx_d             = drainIdx_q + CH_W'(1);
          if (drainIdx_q == LAST_IDX) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      drainIdx_q <= '0;
      entryVld_q <= '0;
      psum_q     <= '0;
      accValid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      drainIdx_q <= drainIdx_d;
      entryVld_q <= entryVld_d;
      psum_q     <= psum_d;
      accValid_q <= accValid_d;
      err_q      <= err_d;
    end
  end

  // Entry data has no reset; the valid bits alone decide what is visible.
  always_ff @(posedge clk_i) begin
    if (wrEn) begin
      entryData_q[psum_bus.pe_out_ch] <= psum_bus.pe_ofmap;
    end
  end

  assign psum_bus.psum       = psum_q;
  assign psum_bus.acc_valid  = accValid_q;
  assign psum_bus.drain_busy = (state_q != IDLE);
  assign psum_bus.drain_done = (state_q == DONE);
  assign psum_bus.wb_valid   = inDrain;
  assign psum_bus.wb_ch      = inDrain ? drainIdx_q : '0;
  assign psum_bus.wb_data    = inDrain ? drainData : '0;
  assign psum_bus.err        = err_q;

endmodule

// File: tb/tb_omem_psum_buffer.sv
// Randomised self-checking bench for omem_psum_buffer against an array-based behavioural model.
// Build with OMEM_RELU_EN defined to check the clamped writeback variant.
module tb_omem_psum_buffer;

  localparam int PSUM_DW = 24;
  localparam int OUT_CH  = 16;
  localparam int CH_W    = 4;

`ifdef OMEM_RELU_EN
  localparam logic [PSUM_DW-1:0] NEG_WB_EXP = 24'h000000;
`else
  localparam logic [PSUM_DW-1:0] NEG_WB_EXP = 24'hFFFFF0;
`endif

  logic clk;
  logic rst;

  omem_psum_buffer_if #(.PSUM_DW(PSUM_DW), .OUT_CH(OUT_CH), .CH_W(CH_W)) bus ();

  omem_psum_buffer #(.PSUM_DW(PSUM_DW), .OUT_CH(OUT_CH), .CH_W(CH_W)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .psum_bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model: what each channel holds and whether it is valid.
  logic [PSUM_DW-1:0] mem [OUT_CH];
  bit   [OUT_CH-1:0]  mVld;
  logic [PSUM_DW-1:0] expPsum;
  logic               expAcc;

  function automatic logic [PSUM_DW-1:0] wbExpect(input int ch);
    logic [PSUM_DW-1:0] v;
    if (ch < 0 || ch >= OUT_CH) return '0;
    v = mVld[ch] ? mem[ch] : '0;
`ifdef OMEM_RELU_EN
    if ($signed(v) < 0) v = '0;
`endif
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One IDLE cycle of PE traffic; the model predicts next-cycle psum/acc_valid.
  task automatic drive_cycle(input bit wv, input int wch, input logic [PSUM_DW-1:0] wd,
                             input bit rr, input int rch);
    bus.pe_out_valid = wv;
    bus.pe_out_ch    = CH_W'(wch);
    bus.pe_ofmap     = wd;
    bus.rd_req       = rr;
    bus.rd_ch        = CH_W'(rch);
    if (rr && wv && wch == rch) begin
      expPsum = wd;
      expAcc  = 1'b1;
    end else if (rr && mVld[rch]) begin
      expPsum = mem[rch];
      expAcc  = 1'b1;
    end else begin
      expPsum = '0;
      expAcc  = 1'b0;
    end
    tick();
    if (wv) begin
      mem[wch]  = wd;
      mVld[wch] = 1'b1;
    end
    bus.pe_out_valid = 1'b0;
    bus.rd_req       = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++; if (bus.psum !== '0) begin errors++; $display("[TB] FAIL reset_psum: got %h expected 0", bus.psum); end
    checks++; if (bus.acc_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_acc_valid: got %b expected 0", bus.acc_valid); end
    checks++; if (bus.drain_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_drain_busy: got %b expected 0", bus.drain_busy); end
    checks++; if (bus.drain_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_drain_done: got %b expected 0", bus.drain_done); end
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_wb_valid: got %b expected 0", bus.wb_valid); end
    checks++; if (bus.wb_ch !== '0) begin errors++; $display("[TB] FAIL reset_wb_ch: got %0d expected 0", bus.wb_ch); end
    checks++; if (bus.wb_data !== '0) begin errors++; $display("[TB] FAIL reset_wb_data: got %h expected 0", bus.wb_data); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", bus.err); end
    rst  = 1'b0;
    mVld = '0;
    tick();
  endtask

  task automatic test_write_read();
    drive_cycle(1'b1, 3, 24'h000123, 1'b0, 0);
    drive_cycle(1'b0, 0, '0, 1'b1, 3);
    checks++; if (bus.psum !== 24'h000123) begin errors++; $display("[TB] FAIL wr_rd_psum: got %h expected 000123", bus.psum); end
    checks++; if (bus.acc_valid !== 1'b1) begin errors++; $display("[TB] FAIL wr_rd_acc: got %b expected 1", bus.acc_valid); end
    drive_cycle(1'b0, 0, '0, 1'b1, 5);
    checks++; if (bus.psum !== '0) begin errors++; $display("[TB] FAIL unwritten_psum: got %h expected 0", bus.psum); end
    checks++; if (bus.acc_valid !== 1'b0) begin errors++; $display("[TB] FAIL unwritten_acc: got %b expected 0", bus.acc_valid); end
    drive_cycle(1'b0, 0, '0, 1'b0, 3);
    checks++; if ({bus.acc_valid, bus.psum} !== '0) begin errors++; $display("[TB] FAIL no_req_psum: got %b/%h expected 0/0", bus.acc_valid, bus.psum); end
  endtask

  task automatic test_bypass();
    drive_cycle(1'b1, 7, 24'hFFFF00, 1'b1, 7);
    checks++; if (bus.psum !== 24'hFFFF00) begin errors++; $display("[TB] FAIL bypass_psum: got %h expected FFFF00", bus.psum); end
    checks++; if (bus.acc_valid !== 1'b1) begin errors++; $display("[TB] FAIL bypass_acc: got %b expected 1", bus.acc_valid); end
    drive_cycle(1'b1, 7, 24'h000010, 1'b0, 0);
    drive_cycle(1'b0, 0, '0, 1'b1, 7);
    checks++; if (bus.psum !== 24'h000010) begin errors++; $display("[TB] FAIL overwrite_psum: got %h expected 000010", bus.psum); end
  endtask

  task automatic test_random_rw();
    for (int i = 0; i < 80; i++) begin
      int wch, rch;
      wch = $urandom_range(0, OUT_CH - 1);
      rch = ($urandom_range(0, 3) == 0) ? wch : $urandom_range(0, OUT_CH - 1);
      drive_cycle(1'($urandom_range(0, 1)), wch, PSUM_DW'($urandom), 1'($urandom_range(0, 1)), rch);
      checks++; if (bus.psum !== expPsum) begin errors++; $display("[TB] FAIL rand_psum[%0d]: got %h expected %h", i, bus.psum, expPsum); end
      checks++; if (bus.acc_valid !== expAcc) begin errors++; $display("[TB] FAIL rand_acc[%0d]: got %b expected %b", i, bus.acc_valid, expAcc); end
    end
  endtask

  // Drain with wb_ready driven by readyMode: 0 always ready, 1 stall 3 cycles at idx 4, 2 random.
  task automatic test_drain_mode(input string name, input int readyMode);
    int  cyc, expIdx, stalls;
    bit  ready;
    cyc    = 1;
    expIdx = 0;
    stalls = 0;
    bus.drain_start = 1'b1;
    tick();
    bus.drain_start = 1'b0;
    cyc = 2;
    while (bus.drain_done !== 1'b1 && cyc < 100) begin
      checks++; if ({bus.wb_valid, bus.wb_ch} !== {1'b1, CH_W'(expIdx)}) begin errors++; $display("[TB] FAIL %s_wb_ch: got v=%b ch=%0d expected v=1 ch=%0d", name, bus.wb_valid, bus.wb_ch, expIdx); end
      checks++; if (bus.wb_data !== wbExpect(expIdx)) begin errors++; $display("[TB] FAIL %s_wb_data[%0d]: got %h expected %h", name, expIdx, bus.wb_data, wbExpect(expIdx)); end
      case (readyMode)
        1:       ready = !(expIdx == 4 && stalls < 3);
        2:       ready = ($urandom_range(0, 2) != 0);
        default: ready = 1'b1;
      endcase
      bus.wb_ready = ready;
      if (ready) begin
        if (expIdx < OUT_CH) mVld[expIdx] = 1'b0;
        expIdx++;
      end else begin
        stalls++;
      end
      tick();
      cyc++;
    end
    bus.wb_ready = 1'b0;
    checks++; if (bus.drain_done !== 1'b1) begin errors++; $display("[TB] FAIL %s_timeout: got drain_done=%b after %0d cycles expected 1", name, bus.drain_done, cyc); end
    checks++; if (cyc !== OUT_CH + 2 + stalls) begin errors++; $display("[TB] FAIL %s_duration: got %0d cycles expected %0d", name, cyc, OUT_CH + 2 + stalls); end
    checks++; if (expIdx !== OUT_CH) begin errors++; $display("[TB] FAIL %s_beats: got %0d expected %0d", name, expIdx, OUT_CH); end
    tick();
    checks++; if ({bus.drain_done, bus.drain_busy, bus.wb_valid} !== 3'b000) begin errors++; $display("[TB] FAIL %s_idle: got done/busy/valid=%b expected 000", name, {bus.drain_done, bus.drain_busy, bus.wb_valid}); end
  endtask

  task automatic test_full_drain();
    for (int i = 0; i < OUT_CH; i++) drive_cycle(1'b1, i, PSUM_DW'(i + 1), 1'b0, 0);
    test_drain_mode("full", 0);
    drive_cycle(1'b0, 0, '0, 1'b1, 6);
    checks++; if (bus.acc_valid !== 1'b0) begin errors++; $display("[TB] FAIL post_drain_acc: got %b expected 0", bus.acc_valid); end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < OUT_CH; i++) drive_cycle(1'b1, i, PSUM_DW'(16 * i + 3), 1'b0, 0);
    test_drain_mode("bp", 1);
  endtask

  task automatic test_relu();
    drive_cycle(1'b1, 1, 24'hFFFFF0, 1'b0, 0);
    drive_cycle(1'b0, 0, '0, 1'b1, 1);
    checks++; if (bus.psum !== 24'hFFFFF0) begin errors++; $display("[TB] FAIL neg_psum: got %h expected FFFFF0", bus.psum); end
    bus.wb_ready    = 1'b0;
    bus.drain_start = 1'b1;
    tick();
    bus.drain_start = 1'b0;
    bus.wb_ready    = 1'b1;
    tick();
    bus.wb_ready = 1'b0;
    checks++; if (bus.wb_ch !== CH_W'(1)) begin errors++; $display("[TB] FAIL neg_wb_ch: got %0d expected 1", bus.wb_ch); end
    checks++; if (bus.wb_data !== NEG_WB_EXP) begin errors++; $display("[TB] FAIL neg_wb_data: got %h expected %h", bus.wb_data, NEG_WB_EXP); end
    rst = 1'b1;
    tick();
    rst  = 1'b0;
    mVld = '0;
  endtask

  task automatic test_random_drain();
    for (int i = 0; i < OUT_CH; i++) begin
      if ($urandom_range(0, 3) != 0) drive_cycle(1'b1, i, PSUM_DW'($urandom), 1'b0, 0);
    end
    test_drain_mode("rand", 2);
  endtask

  task automatic test_conflict();
    drive_cycle(1'b1, 2, 24'h0ABCDE, 1'b0, 0);
    bus.wb_ready    = 1'b0;
    bus.drain_start = 1'b1;
    tick();
    bus.drain_start  = 1'b0;
    bus.pe_out_valid = 1'b1;
    bus.pe_out_ch    = CH_W'(2);
    bus.pe_ofmap     = 24'h555555;
    bus.rd_req       = 1'b1;
    bus.rd_ch        = CH_W'(2);
    tick();
    bus.pe_out_valid = 1'b0;
    bus.rd_req       = 1'b0;
    checks++; if (bus.err !== 1'b1) begin errors++; $display("[TB] FAIL conflict_err: got %b expected 1", bus.err); end
    checks++; if ({bus.acc_valid, bus.psum} !== '0) begin errors++; $display("[TB] FAIL conflict_psum: got %b/%h expected 0/0", bus.acc_valid, bus.psum); end
    checks++; if (bus.wb_ch !== '0) begin errors++; $display("[TB] FAIL conflict_idx: got %0d expected 0", bus.wb_ch); end
    bus.wb_ready = 1'b1;
    tick();
    tick();
    bus.wb_ready = 1'b0;
    checks++; if (bus.wb_data !== 24'h0ABCDE) begin errors++; $display("[TB] FAIL conflict_storage: got %h expected 0ABCDE", bus.wb_data); end
    tick();
    checks++; if (bus.err !== 1'b1) begin errors++; $display("[TB] FAIL conflict_err_sticky: got %b expected 1", bus.err); end
  endtask

  task automatic test_reset_mid_drain();
    int guard;
    for (int i = 0; i < OUT_CH; i++) drive_cycle(1'b1, i, PSUM_DW'(i + 100), 1'b0, 0);
    guard = 0;
    bus.wb_ready = 1'b1;
    while (bus.wb_ch !== CH_W'(9) && guard < 50) begin
      tick();
      guard++;
    end
    checks++; if (bus.wb_ch !== CH_W'(9)) begin errors++; $display("[TB] FAIL mid_reach_idx9: got %0d expected 9", bus.wb_ch); end
    rst = 1'b1;
    tick();
    rst          = 1'b0;
    bus.wb_ready = 1'b0;
    mVld         = '0;
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_wb_valid: got %b expected 0", bus.wb_valid); end
    checks++; if (bus.drain_busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_busy: got %b expected 0", bus.drain_busy); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_err: got %b expected 0", bus.err); end
    for (int i = 0; i < OUT_CH; i++) begin
      drive_cycle(1'b0, 0, '0, 1'b1, i);
      checks++; if (bus.drain_done !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_done[%0d]: got %b expected 0", i, bus.drain_done); end
      checks++; if ({bus.acc_valid, bus.psum} !== {expAcc, expPsum}) begin errors++; $display("[TB] FAIL mid_rst_vld[%0d]: got %b/%h expected %b/%h", i, bus.acc_valid, bus.psum, expAcc, expPsum); end
    end
  endtask

  initial begin
    rst              = 1'b1;
    bus.pe_out_valid = 1'b0;
    bus.pe_out_ch    = '0;
    bus.pe_ofmap     = '0;
    bus.rd_req       = 1'b0;
    bus.rd_ch        = '0;
    bus.drain_start  = 1'b0;
    bus.wb_ready     = 1'b0;
    mVld             = '0;
    for (int i = 0; i < OUT_CH; i++) mem[i] = '0;

    test_reset();
    test_write_read();
    test_bypass();
    test_random_rw();
    test_full_drain();
    test_backpressure();
    test_relu();
    test_random_drain();
    test_conflict();
    test_reset_mid_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
